wb_config_responder: RTL and testbench

Wishbone slave that accepts configuration writes from the management SoC and serializes them into the per-column configuration shift chains of the FPGA fabric. One byte lane of the 32-bit data bus feeds each fabric column. A programmable per-lane bit count lets the final partial byte of a column bitstream be shifted without padding. It sits between the top-level Wishbone port and the column config chains inside `fpga`.

---
 rtl/wb_config_responder.sv | 215 +++++++++++++++++++++
 tb/tb_wb_config_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_config_responder.sv
// -----------------------------------------------------------------------------
// wb_config_responder
//
// Wishbone slave that turns configuration writes into serial bit streams for
// the per-column configuration shift chains of the fabric. Byte lane k of the
// data bus feeds column k. A per-lane bit count (0..8) allows the last,
// partial byte of a column bitstream to be shifted without padding.
//
// Registers (byte addresses, full compare):
//   BASE+0  STATUS  RO  always reads 0 (the bus is stalled while shifting)
//   BASE+1  COUNT   RW  byte k = bit count of lane k, values >= 8 stored as 8
//   BASE+2  DATA    RW  write latches selected lanes and starts a shift
//
// Ports:
//   wb_clk_i    in   1   bus and config chain clock
//   wb_rst_i    in   1   synchronous active-high reset
//   wbs_stb_i   in   1   strobe
//   wbs_cyc_i   in   1   cycle valid
//   wbs_we_i    in   1   1 = write, 0 = read
//   wbs_sel_i   in   4   byte-lane select, lane k = column k
//   wbs_data_i  in   32  write data
//   wbs_addr_i  in   32  byte address
//   wbs_ack_o   out  1   single-cycle acknowledge
//   wbs_data_o  out  32  read data, zero outside the ack cycle
//   cfg_en_o    out  MX  per-column shift enable
//   cfg_data_o  out  MX  per-column serial bit, LSB first
//   busy_o      out  1   high while shifting
// -----------------------------------------------------------------------------
module wb_config_responder #(
    parameter int          MX        = 3,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_data_i,
    input  logic [31:0]   wbs_addr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_data_o,
    output logic [MX-1:0] cfg_en_o,
    output logic [MX-1:0] cfg_data_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t        state, state_next;

    logic [3:0]    count    [MX];
    logic [7:0]    data_lat [MX];
    logic [MX-1:0] sel_lat, sel_next;
    logic [3:0]    n_len, n_next, n_req;
    logic [3:0]    step, step_next;

    logic          ack_r, ack_next;
    logic [31:0]   rdata_r, rdata_next, rdata_mux;
    logic [MX-1:0] en_r, en_next;
    logic [MX-1:0] bit_r, bit_next;
    logic          busy_r, busy_next;

    logic          req;
    logic          hit_status, hit_count, hit_data;
    logic          count_we, data_we;

    // Byte lanes above MX have no column behind them; folding them here keeps
    // every input bit visibly consumed.
    logic          unused_lanes;
    assign unused_lanes = ^{wbs_sel_i, wbs_data_i};

    function automatic logic [3:0] sat_count(input logic [7:0] v);
        return (v >= 8'd8) ? 4'd8 : v[3:0];
    endfunction

    assign req        = wbs_cyc_i & wbs_stb_i & ~ack_r;
    assign hit_status = (wbs_addr_i == BASE_ADDR);
    assign hit_count  = (wbs_addr_i == BASE_ADDR + 32'd1);
    assign hit_data   = (wbs_addr_i == BASE_ADDR + 32'd2);

    // Shift length is the longest count among the selected, existing lanes.
    always_comb begin
        n_req = 4'd0;
        for (int k = 0; k < MX; k++) begin
            if (wbs_sel_i[k] && (count[k] > n_req)) begin
                n_req = count[k];
            end
        end
    end

    always_comb begin
        rdata_mux = 32'd0;
        if (hit_count) begin
            for (int k = 0; k < MX; k++) begin
                rdata_mux[8*k +: 8] = {4'd0, count[k]};
            end
        end else if (hit_data) begin
            for (int k = 0; k < MX; k++) begin
                rdata_mux[8*k +: 8] = data_lat[k];
            end
        end else if (hit_status) begin
            rdata_mux = 32'd0;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        n_next     = n_len;
        sel_next   = sel_lat;
        ack_next   = 1'b0;
        rdata_next = 32'd0;
        en_next    = '0;
        bit_next   = '0;
        busy_next  = 1'b0;
        count_we   = 1'b0;
        data_we    = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    count_we = wbs_we_i & hit_count;
                    data_we  = wbs_we_i & hit_data;
                    if (data_we && (n_req != 4'd0)) begin
                        // First bit goes out on the accepting edge, taken
                        // straight from the bus since the latch loads now.
                        state_next = SHIFT;
                        step_next  = 4'd1;
                        n_next     = n_req;
                        sel_next   = wbs_sel_i[MX-1:0];
                        busy_next  = 1'b1;
                        for (int k = 0; k < MX; k++) begin
                            en_next[k]  = wbs_sel_i[k] && (count[k] != 4'd0);
                            bit_next[k] = en_next[k] & wbs_data_i[8*k];
                        end
                    end else begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                        if (!wbs_we_i) begin
                            rdata_next = rdata_mux;
                        end
                    end
                end
            end
            SHIFT: begin
                // step is the index of the bit being registered this edge.
                if (step == n_len) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                end else begin
                    busy_next = 1'b1;
                    step_next = step + 4'd1;
                    for (int k = 0; k < MX; k++) begin
                        en_next[k]  = sel_lat[k] && (step < count[k]);
                        bit_next[k] = en_next[k] & data_lat[k][step[2:0]];
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            step    <= 4'd0;
            n_len   <= 4'd0;
            sel_lat <= '0;
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
            en_r    <= '0;
            bit_r   <= '0;
            busy_r  <= 1'b0;
            for (int k = 0; k < MX; k++) begin
                count[k]    <= 4'd8;
                data_lat[k] <= 8'd0;
            end
        end else begin
            state   <= state_next;
            step    <= step_next;
            n_len   <= n_next;
            sel_lat <= sel_next;
            ack_r   <= ack_next;
            rdata_r <= rdata_next;
            en_r    <= en_next;
            bit_r   <= bit_next;
            busy_r  <= busy_next;
            for (int k = 0; k < MX; k++) begin
                if (count_we && wbs_sel_i[k]) begin
                    count[k] <= sat_count(wbs_data_i[8*k +: 8]);
                end
                if (data_we && wbs_sel_i[k]) begin
                    data_lat[k] <= wbs_data_i[8*k +: 8];
                end
            end
        end
    end

    assign wbs_ack_o  = ack_r;
    assign wbs_data_o = rdata_r;
    assign cfg_en_o   = en_r;
    assign cfg_data_o = bit_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_wb_config_responder.sv
// -----------------------------------------------------------------------------
// tb_wb_config_responder
//
// Directed bench with a scoreboard. The stimulus process pushes the expected
// ack (cycle and read data) and the expected per-cycle config bits into queues
// before issuing each transfer; a monitor compares them against the DUT every
// falling edge.
// Cycle numbering: a request sampled at rising edge T makes its first
// registered response visible in cycle T+1.
// -----------------------------------------------------------------------------
module tb_wb_config_responder;

    localparam int          MX   = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   wdata, addr;
    logic          ack;
    logic [31:0]   rdata;
    logic [MX-1:0] cen, cdat;
    logic          busy;

    wb_config_responder #(.MX(MX), .BASE_ADDR(BASE)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_data_i (wdata),
        .wbs_addr_i (addr),
        .wbs_ack_o  (ack),
        .wbs_data_o (rdata),
        .cfg_en_o   (cen),
        .cfg_data_o (cdat),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          t;
        int          lat;
    } ack_exp_t;

    typedef struct {
        int   lane;
        logic b;
        int   cyc;
    } bit_exp_t;

    ack_exp_t ack_q[$];
    bit_exp_t bit_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int en0_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc_cnt + 1);
        end
    endfunction

    // Expected serial stream of one lane: bit s of byte_v in cycle t+1+s.
    task automatic push_lane(input int lane, input logic [7:0] byte_v, input int nbits, input int t);
        bit_exp_t e;
        for (int s = 0; s < nbits; s++) begin
            e.lane = lane;
            e.b    = byte_v[s];
            e.cyc  = t + 1 + s;
            bit_q.push_back(e);
        end
    endtask

    // Monitor: compares config outputs every cycle and pops the ack queue.
    always @(negedge clk) begin
        int            now;
        logic [MX-1:0] xen, xdat;
        ack_exp_t      a;
        now  = cyc_cnt + 1;
        xen  = '0;
        xdat = '0;
        for (int i = bit_q.size() - 1; i >= 0; i--) begin
            if (bit_q[i].cyc == now) begin
                xen[bit_q[i].lane]  = 1'b1;
                xdat[bit_q[i].lane] = bit_q[i].b;
                bit_q.delete(i);
            end else if (bit_q[i].cyc < now) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_bit: lane %0d cycle %0d got nothing expected enable", bit_q[i].lane, bit_q[i].cyc);
                bit_q.delete(i);
            end
        end
        chk("cfg_en", 32'(cen), 32'(xen));
        chk("cfg_data", 32'(cdat), 32'(xdat));
        chk("busy", 32'(busy), 32'(|xen));
        if (cen[0] === 1'b1) en0_cnt++;
        if (ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_ack: got ack expected none (cycle %0d)", now);
            end else begin
                a = ack_q.pop_front();
                chk({a.name, "_latency"}, 32'(now - a.t), 32'(a.lat));
                chk({a.name, "_rdata"}, rdata, a.data);
            end
        end else begin
            chk("ack_low", 32'(ack), 32'd0);
            chk("rdata_idle", rdata, 32'd0);
        end
    end

    task automatic idle();
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        sel   = 4'd0;
        wdata = 32'd0;
        addr  = 32'd0;
    endtask

    // Issue one transfer at the current falling edge, wait for its ack,
    // release the bus, and return on the next falling edge.
    task automatic xfer(input string name, input logic [31:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int lat);
        ack_exp_t e;
        bit       got;
        e.name = name;
        e.data = exp_rd;
        e.t    = cyc_cnt + 1;
        e.lat  = lat;
        ack_q.push_back(e);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        sel   = s;
        wdata = d;
        addr  = a;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", name);
            void'(ack_q.pop_back());
        end
        idle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base_cnt;
        rst = 1'b1;
        idle();

        // Reset held for 5 cycles; monitor checks outputs stay 0.
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xfer("rd_count_rst", BASE + 1, 1'b0, 4'hF, 32'd0, 32'h0008_0808, 1);
        xfer("rd_status", BASE + 0, 1'b0, 4'hF, 32'd0, 32'h0000_0000, 1);

        // Full-byte shift on all lanes, count 8.
        t = cyc_cnt + 1;
        push_lane(0, 8'h81, 8, t);
        push_lane(1, 8'h3C, 8, t);
        push_lane(2, 8'hA5, 8, t);
        xfer("wr_data_full", BASE + 2, 1'b1, 4'hF, 32'h00A5_3C81, 32'd0, 9);
        xfer("rd_data_full", BASE + 2, 1'b0, 4'hF, 32'd0, 32'h00A5_3C81, 1);

        // Partial byte: lane0 5 bits, lane1 3 bits, lane2 unselected.
        xfer("wr_count_part", BASE + 1, 1'b1, 4'hF, 32'h0000_0305, 32'd0, 1);
        xfer("rd_count_part", BASE + 1, 1'b0, 4'hF, 32'd0, 32'h0000_0305, 1);
        t = cyc_cnt + 1;
        push_lane(0, 8'hFF, 5, t);
        push_lane(1, 8'hFF, 3, t);
        xfer("wr_data_part", BASE + 2, 1'b1, 4'b0011, 32'h0000_FFFF, 32'd0, 6);
        xfer("rd_data_part", BASE + 2, 1'b0, 4'hF, 32'd0, 32'h00A5_FFFF, 1);

        // Saturation and zero count.
        xfer("wr_count_ff", BASE + 1, 1'b1, 4'hF, 32'h0000_00FF, 32'd0, 1);
        xfer("rd_count_ff", BASE + 1, 1'b0, 4'hF, 32'd0, 32'h0000_0008, 1);
        xfer("wr_count_sat", BASE + 1, 1'b1, 4'hF, 32'h0908_0A07, 32'd0, 1);
        xfer("rd_count_sat", BASE + 1, 1'b0, 4'hF, 32'd0, 32'h0008_0807, 1);
        xfer("wr_count_zero", BASE + 1, 1'b1, 4'hF, 32'h0808_0800, 32'd0, 1);
        xfer("wr_data_zero", BASE + 2, 1'b1, 4'b0001, 32'h0000_0055, 32'd0, 1);
        xfer("rd_data_zero", BASE + 2, 1'b0, 4'hF, 32'd0, 32'h00A5_FF55, 1);

        // Unmapped address: acked, no effect, reads 0.
        xfer("wr_unmapped", BASE + 7, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0, 1);
        xfer("rd_unmapped", BASE + 7, 1'b0, 4'hF, 32'd0, 32'h0000_0000, 1);
        xfer("rd_count_unm", BASE + 1, 1'b0, 4'hF, 32'd0, 32'h0008_0800, 1);
        xfer("rd_data_unm", BASE + 2, 1'b0, 4'hF, 32'd0, 32'h00A5_FF55, 1);
        xfer("wr_count_pre", BASE + 1, 1'b1, 4'hF, 32'h0004_0508, 32'd0, 1);

        // Reset during an 8-bit shift, asserted while bit s=3 is on the chains.
        t = cyc_cnt + 1;
        push_lane(0, 8'h56, 4, t);
        push_lane(1, 8'h34, 4, t);
        push_lane(2, 8'h12, 4, t);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        sel   = 4'hF;
        addr  = BASE + 2;
        wdata = 32'h0012_3456;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        xfer("rd_count_midrst", BASE + 1, 1'b0, 4'hF, 32'd0, 32'h0008_0808, 1);
        xfer("rd_data_midrst", BASE + 2, 1'b0, 4'hF, 32'd0, 32'h0000_0000, 1);

        // Back-to-back DATA writes on lane 0; second accepted at T+10.
        base_cnt = en0_cnt;
        t = cyc_cnt + 1;
        push_lane(0, 8'hF0, 8, t);
        push_lane(0, 8'h0F, 8, t + 10);
        xfer("wr_b2b_1", BASE + 2, 1'b1, 4'b0001, 32'h0000_00F0, 32'd0, 9);
        xfer("wr_b2b_2", BASE + 2, 1'b1, 4'b0001, 32'h0000_000F, 32'd0, 9);
        chk("b2b_enable_total", 32'(en0_cnt - base_cnt), 32'd16);

        repeat (5) @(negedge clk);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("bit_queue_drained", 32'(bit_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
